// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator, one bit per cycle, valid/ready on both sides.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opd;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic                 neg_q;

    // ---------------- operand decode (IDLE) ----------------
    logic             a_signed, b_signed, sign_a, sign_b, neg_in;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign sign_a   = a_signed & a[WIDTH-1];
    assign sign_b   = b_signed & b[WIDTH-1];
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    assign neg_in   = (op[2] & op[1]) ? sign_a : (sign_a ^ sign_b);

    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign special  = div_zero || div_ovf;
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : a;
    end

    // ---------------- iteration datapath (CALC) ----------------
    logic [WIDTH:0]     mul_sum, div_ext;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : '0)};
    // Partial remainder after the left shift needs WIDTH+1 bits before the trial subtract.
    assign div_ext  = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge   = div_ext >= {1'b0, opd};
    assign div_diff = WIDTH'(div_ext - {1'b0, opd});

    always_comb begin
        step = {mul_sum, acc[WIDTH-1:1]};
        if (op_q[2])
            step = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end

    // ---------------- sign fix and output select (FIX) ----------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   qr_sel, qr_fix, fix_res;

    assign prod   = neg_q ? -acc : acc;
    assign qr_sel = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    assign qr_fix = neg_q ? -qr_sel : qr_sel;

    always_comb begin
        fix_res = prod[2*WIDTH-1:WIDTH];
        if (op_q[2])
            fix_res = qr_fix;
        else if (op_q[1:0] == 2'd0)
            fix_res = prod[WIDTH-1:0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
                CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            opd    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            unique case (state)
                IDLE: if (in_valid) begin
                    op_q  <= op;
                    neg_q <= neg_in;
                    if (special) begin
                        result <= special_res;
                    end else begin
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                        acc <= {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
                        opd <= op[2] ? mag_b : mag_a;
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one WIDTH=32 and one WIDTH=8 instance,
// directed vectors push expected results; a negedge monitor pops and compares.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, sel8;
    logic [2:0]  op;
    logic [31:0] a, b;

    logic        in_ready32, out_valid32, in_ready8, out_valid8;
    logic [31:0] result32;
    logic [7:0]  result8;
    logic        in_valid32, in_valid8;

    int checks = 0;
    int errors = 0;
    logic [31:0] q32[$];
    logic [31:0] q8[$];

    assign in_valid32 = in_valid & ~sel8;
    assign in_valid8  = in_valid & sel8;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op), .a(a), .b(b), .out_valid(out_valid32), .out_ready(out_ready), .result(result32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(out_valid8), .out_ready(out_ready), .result(result8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ov(input bit w8);
        return w8 ? out_valid8 : out_valid32;
    endfunction

    function automatic logic ir(input bit w8);
        return w8 ? in_ready8 : in_ready32;
    endfunction

    // Monitor: compare on every completed output handshake; flag any unexpected result.
    always @(negedge clk) begin
        if (out_valid32) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out32: got result %h expected no output", result32);
            end else if (out_ready) begin
                chk("result32", result32, q32.pop_front());
            end
        end
        if (out_valid8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out8: got result %h expected no output", result8);
            end else if (out_ready) begin
                chk("result8", {24'h0, result8}, q8.pop_front());
            end
        end
    end

    // Issue one op, push its expected result, then wait for out_valid and check edge latency.
    task automatic issue(input bit w8, input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] exp, input int lat);
        int n = 0;
        chk("in_ready_before_issue", {31'h0, ir(w8)}, 32'h1);
        sel8 = w8; op = o; a = aa; b = bb; in_valid = 1'b1;
        if (w8) q8.push_back(exp & 32'hFF);
        else    q32.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0; op = 3'd5;
        while (!ov(w8) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("out_valid_seen", {31'h0, ov(w8)}, 32'h1);
        if (lat >= 0) chk("latency_edges", 32'(n), 32'(lat));
    endtask

    task automatic retire(input bit w8);
        @(posedge clk); #1;
        chk("in_ready_after_retire", {30'h0, ir(w8), ov(w8)}, 32'h2);
    endtask

    task automatic quiet(input int cycles, input bit w8);
        logic bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ov(w8) || !ir(w8)) bad = 1'b1;
        end
        chk("quiet_idle", {31'h0, bad}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel8 = 1'b0;
        op = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid32", {31'h0, out_valid32}, 32'h0);
        chk("reset_result32", result32, 32'h0);
        chk("reset_in_ready32", {31'h0, in_ready32}, 32'h1);
        chk("reset_in_ready8", {31'h0, in_ready8}, 32'h1);

        // Multiply, WIDTH=32
        issue(0, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33); retire(0);
        issue(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33); retire(0);
        issue(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33); retire(0);
        issue(0, 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33); retire(0);
        // Divide, WIDTH=32
        issue(0, 3'd4, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFD, 33); retire(0);
        issue(0, 3'd6, 32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 33); retire(0);
        issue(0, 3'd5, 32'd100,      32'd7,   32'd14,       33); retire(0);
        issue(0, 3'd7, 32'd100,      32'd7,   32'd2,        33); retire(0);
        // Special cases: latency 1
        issue(0, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0); retire(0);
        issue(0, 3'd6, 32'd5,        32'd0,        32'd5,        0); retire(0);
        issue(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0); retire(0);
        issue(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0); retire(0);

        // Backpressure
        out_ready = 1'b0;
        issue(0, 3'd5, 32'd100, 32'd7, 32'd14, 33);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_ready", {30'h0, out_valid32, in_ready32}, 32'h2);
            chk("bp_result", result32, 32'd14);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        retire(0);
        issue(0, 3'd7, 32'd100, 32'd7, 32'd2, 33); retire(0);

        // Flush mid-CALC with a simultaneous request that must be dropped
        sel8 = 1'b0; op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {30'h0, in_ready32, out_valid32}, 32'h2);
        quiet(40, 0);
        issue(0, 3'd0, 32'd3, 32'd4, 32'd12, 33); retire(0);

        // Reset mid-CALC
        sel8 = 1'b0; op = 3'd0; a = 32'd7; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_calc_out_valid", {31'h0, out_valid32}, 32'h0);
        chk("rst_calc_result", result32, 32'h0);
        quiet(40, 0);

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        issue(0, 3'd0, 32'd2, 32'd3, 32'd6, 33);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q32.delete();
        out_ready = 1'b1;
        chk("rst_done_out_valid", {31'h0, out_valid32}, 32'h0);
        chk("rst_done_result", result32, 32'h0);
        quiet(10, 0);

        // WIDTH=8 instance
        issue(1, 3'd0, 32'h7F, 32'h7F, 32'h01, 9); retire(1);
        issue(1, 3'd3, 32'hFF, 32'hFF, 32'hFE, 9); retire(1);
        issue(1, 3'd4, 32'hF9, 32'h02, 32'hFD, 9); retire(1);
        issue(1, 3'd6, 32'hF9, 32'h02, 32'hFF, 9); retire(1);
        issue(1, 3'd5, 32'h05, 32'h00, 32'hFF, 0); retire(1);
        issue(1, 3'd4, 32'h80, 32'hFF, 32'h80, 0); retire(1);
        out_ready = 1'b0;
        issue(1, 3'd7, 32'd100, 32'd7, 32'd2, 9);
        for (int i = 0; i < 10; i++) begin
            chk("bp8_valid_ready", {30'h0, out_valid8, in_ready8}, 32'h2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        retire(1);
        sel8 = 1'b1; op = 3'd0; a = 32'h11; b = 32'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        quiet(15, 1);
        issue(1, 3'd0, 32'd3, 32'd4, 32'd12, 9); retire(1);

        repeat (5) @(posedge clk);
        #1 chk("queues_drained", 32'(q32.size() + q8.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage; implements the RV32M operations alongside the single-cycle integer ALU.
- Processes one bit per cycle in a shift-add multiplier and a restoring divider that share one datapath.
- Uses a valid/ready handshake on both sides, so the pipeline stalls while `in_ready` is low and can apply backpressure on the result.
- Pipeline flush aborts an operation in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abort the current operation; synchronous, one cycle.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept an operation; high only in IDLE.
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  input  WIDTH  rs1 operand.
- b  input  WIDTH  rs2 operand.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result; stable while out_valid=1.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_valid=0; result=0; counter=0.
  - in_ready=1 from the cycle after reset deasserts.
  - rst dominates flush and all handshakes.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge, latch op, a and b.
- Special cases, IDLE→DONE directly, with out_valid=1 in the next cycle (latency 1):
  - Divide by zero (b=0, op 4..7): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (op 4 or 6, a=1<<(WIDTH-1), b=all-ones): DIV gives a; REM gives 0.
- Otherwise IDLE→CALC:
  - Load magnitudes: signed ops take the absolute value of each signed operand. MULHSU treats a as signed and b as unsigned.
  - Record the result sign: for multiply, sign_a XOR sign_b; for the quotient, sign_a XOR sign_b; for the remainder, sign_a.
  - Clear the 2*WIDTH accumulator; set counter=WIDTH.
- CALC, one iteration per cycle, counter decrements:
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right by 1.
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set the quot LSB.
  - When the counter reaches 0 after the last iteration, go to FIX.
- FIX, one cycle:
  - Apply two's-complement negation if the result sign is set. Multiply negates the full 2*WIDTH product.
  - Select the output: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits; DIV/DIVU take quot; REM/REMU take rem.
  - Register into result; go to DONE.
- Normal latency: the accept edge is edge 0; out_valid=1 in the cycle after edge WIDTH+1 (34 cycles for WIDTH=32).
- DONE:
  - out_valid=1; result held.
  - On out_ready=1 at an edge, go to IDLE with out_valid=0.
  - in_ready=0 in DONE, so there is no overlap of accept and retire.
- Flush=1 at an edge in any state:
  - Go to IDLE; out_valid=0; the pending result is discarded.
  - A simultaneous in_valid is ignored (not accepted).
- in_valid while in_ready=0 has no effect; the source must hold its request.
- Changes on a/b/op after acceptance have no effect.
- All arithmetic is performed on WIDTH+1-bit trial differences and a 2*WIDTH product, with no lost carries.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → result 0xFFFFFFEB, out_valid exactly 34 cycles after accept; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE; MULH a=b=0xFFFFFFFF → 0x00000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5; both with latency 1. Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result and out_valid stable and in_ready=0 throughout; out_ready=1 → IDLE next cycle; a back-to-back second op is accepted and correct.
- Flush at CALC iteration 10, with in_valid=1 in the same cycle → out_valid never asserts; in_ready=1 the next cycle; that op is not accepted; a following MUL 3*4 → 12.
- rst asserted mid-CALC and in DONE → out_valid=0, result=0 the next cycle; no stale result later. Rerun the scenarios with WIDTH=8 (MUL 0x7F*0x7F low byte → 0x01; latency 10).
